// File: rtl/usb_tx_pkg.sv
// Shared types, CRC16 constants and the byte-wise CRC16 update for usb_tx_framer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PID  = 3'd1,
    DATA = 3'd2,
    CRC1 = 3'd3,
    CRC2 = 3'd4
  } tx_state_e;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  // USB CRC16, reflected form: fold one byte in LSB-first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data_byte);
    logic [15:0] c;
    c = crc ^ {8'h00, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Registered USB CRC16 accumulator: init reloads the seed, en folds in one byte.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= CRC16_INIT;
    end else if (init) begin
      crc_reg <= CRC16_INIT;
    end else if (en) begin
      crc_reg <= crc16_next(crc_reg, data_byte);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/usb_tx_framer.sv
// Frames PID + payload (+ optional CRC16) onto a byte valid/ready transmit port.
// Define USB_TX_CRC_EN to append the CRC16 bytes (CRC1/CRC2 states).
module usb_tx_framer
  import usb_tx_pkg::*;
#(
  parameter  int MAX_LEN    = 64,
  parameter  int HIST_DEPTH = 10,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_data,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [3:0]            pid,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic [HIST_DEPTH-1:0] hist
);

  tx_state_e             state_reg;
  logic [3:0]            pid_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      cnt_reg;
  logic [HIST_DEPTH-1:0] hist_reg;
  logic                  fire;
  logic                  last_byte;

  assign fire      = tx_valid & tx_ready;
  assign last_byte = (cnt_reg + LEN_W'(1)) == len_reg;

`ifdef USB_TX_CRC_EN
  localparam bit CRC_EN = 1'b1;
  logic [15:0] crc;

  usb_crc16 u_crc (
    .clk       (clk),
    .reset     (reset),
    .init      (state_reg == PID),
    .en        ((state_reg == DATA) && fire),
    .data_byte (data_in),
    .crc       (crc)
  );
`else
  localparam bit CRC_EN = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pid_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      hist_reg  <= '0;
    end else begin
      hist_reg <= {hist_reg[HIST_DEPTH-2:0], fire};
      case (state_reg)
        IDLE: begin
          if (send_data) begin
            pid_reg   <= pid;
            len_reg   <= (pkt_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pkt_len;
            cnt_reg   <= '0;
            state_reg <= PID;
          end
        end
        PID: begin
          if (fire) begin
            if (len_reg != '0) state_reg <= DATA;
            else               state_reg <= CRC_EN ? CRC1 : IDLE;
          end
        end
        DATA: begin
          if (fire) begin
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (last_byte) state_reg <= CRC_EN ? CRC1 : IDLE;
          end
        end
`ifdef USB_TX_CRC_EN
        CRC1: if (fire) state_reg <= CRC2;
        CRC2: if (fire) state_reg <= IDLE;
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // DATA is a pure pass-through so payload beats cost no extra cycle.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    data_ready = 1'b0;
    case (state_reg)
      PID: begin
        tx_valid = 1'b1;
        tx_data  = {~pid_reg, pid_reg};
        tx_last  = !CRC_EN && (len_reg == '0);
      end
      DATA: begin
        tx_valid   = data_valid;
        tx_data    = data_in;
        data_ready = tx_ready;
        tx_last    = !CRC_EN && last_byte;
      end
`ifdef USB_TX_CRC_EN
      CRC1: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[7:0];
      end
      CRC2: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[15:8];
        tx_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign hist = hist_reg;

endmodule

// File: tb/tb_usb_tx_framer.sv
// Self-checking bench for usb_tx_framer: directed cases plus randomized packets vs a reference model.
module tb_usb_tx_framer;

  localparam int MAX_LEN = 64;
  localparam int HD      = 10;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef USB_TX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             send_data;
  logic [LEN_W-1:0] pkt_len;
  logic [3:0]       pid;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic             tx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_last;
  logic             busy;
  logic [HD-1:0]    hist;

  usb_tx_framer #(.MAX_LEN(MAX_LEN), .HIST_DEPTH(HD)) dut (
    .clk        (clk),
    .reset      (reset),
    .send_data  (send_data),
    .pkt_len    (pkt_len),
    .pid        (pid),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .busy       (busy),
    .hist       (hist)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  int          n_pay;
  logic [HD-1:0] model_hist;
  bit          exp_fire;
  int          ready_mode, valid_rand, stall_idx, gap_idx, pulse_idx, abort_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bit-serial USB CRC16 over the payload; returns the transmitted (inverted) value.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay_q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic build_exp(input logic [3:0] p);
    logic [15:0] crc;
    exp_q = {};
    exp_q.push_back({~p, p});
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    if (CRC_EN) begin
      crc = model_crc();
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
  endtask

  task automatic random_payload(input int n);
    pay_q = {};
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    n_pay = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_hist = {model_hist[HD-2:0], exp_fire};
    exp_fire   = 1'b0;
  endtask

  task automatic reset_cfg();
    ready_mode = 0; valid_rand = 0;
    stall_idx = -1; gap_idx = -1; pulse_idx = -1; abort_idx = -1;
  endtask

  task automatic run_packet(input logic [3:0] p, input int len_req, output int cycles);
    int idx, src, stall_n, gap_n, gap_resume;
    bit is_data, rdy, vld;
    send_data = 1'b1; pid = p; pkt_len = LEN_W'(len_req);
    tx_ready = 1'b0; data_valid = 1'b0;
    step();
    send_data = 1'b0; pid = 4'($urandom); pkt_len = LEN_W'($urandom);
    idx = 0; src = 0; cycles = 0; stall_n = 0; gap_n = 0; gap_resume = -10;
    while (idx < exp_q.size() && cycles < 2000) begin
      if (idx == abort_idx) return;
      is_data = (idx >= 1) && (idx <= n_pay);
      rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (idx == stall_idx && stall_n < 2) begin rdy = 1'b0; stall_n++; end
      vld = valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == gap_idx && gap_n < 3) begin
        vld = 1'b0; gap_n++;
        if (gap_n == 3) gap_resume = cycles + 1;
      end
      tx_ready   = rdy;
      data_valid = vld;
      data_in    = (src < pay_q.size()) ? pay_q[src] : 8'h00;
      send_data  = (idx == pulse_idx);
      @(negedge clk);
      check("busy", busy, 1);
      check("hist", hist, model_hist);
      if (cycles == gap_resume + 1) check("hist_gap", hist[3:0], 4'b0001);
      if (is_data) begin
        check("data_valid", tx_valid, vld);
        check("data_ready", data_ready, rdy);
      end else begin
        check("ctl_valid", tx_valid, 1);
        check("ctl_data", tx_data, exp_q[idx]);
      end
      exp_fire = rdy && (is_data ? vld : 1'b1);
      if (exp_fire) begin
        check("beat", tx_data, exp_q[idx]);
        check("last", tx_last, (idx == exp_q.size() - 1));
        if (is_data) src++;
        idx++;
      end
      cycles++;
      step();
    end
    check("timeout", idx, exp_q.size());
    tx_ready = 1'b0; data_valid = 1'b0; send_data = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", tx_valid, 0);
    $display("packet pid=%0h len_req=%0d beats=%0d cycles=%0d", p, len_req, exp_q.size(), cycles);
  endtask

  task automatic ascii_payload();
    pay_q = {};
    for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
    n_pay = 9;
    exp_q = {8'hC3};
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    if (CRC_EN) begin
      exp_q.push_back(8'hC8);
      exp_q.push_back(8'hB4);
    end
  endtask

  initial begin
    int cyc;
    int len;
    reset = 1'b1; send_data = 1'b0; pkt_len = '0; pid = '0;
    data_in = '0; data_valid = 1'b0; tx_ready = 1'b0;
    model_hist = '0; exp_fire = 1'b0;
    reset_cfg();
    step(); step();
    reset = 1'b0; model_hist = '0;
    data_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_last", tx_last, 0);
    check("rst_dready", data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_hist", hist, 0);
    $display("reset state checked");
    step();

    // Known-answer packet: "123456789", full-rate transmitter.
    ascii_payload();
    run_packet(4'h3, 9, cyc);
    check("ascii_cycles", cyc, exp_q.size());
    step();

    // Empty payload.
    pay_q = {}; n_pay = 0;
    exp_q = {8'h4B};
    if (CRC_EN) begin exp_q.push_back(8'h00); exp_q.push_back(8'h00); end
    run_packet(4'hB, 0, cyc);
    step();

    // Stall the first CRC beat (or PID without CRC) for two cycles.
    ascii_payload();
    stall_idx = CRC_EN ? 10 : 0;
    run_packet(4'h3, 9, cyc);
    check("stall_cycles", cyc, exp_q.size() + 2);
    reset_cfg();
    step();

    // Source gap of three cycles mid-payload.
    random_payload(8);
    build_exp(4'h5);
    gap_idx = 4;
    run_packet(4'h5, 8, cyc);
    check("gap_cycles", cyc, exp_q.size() + 3);
    reset_cfg();
    step();

    // Over-long request is clamped; a start pulse during DATA is ignored.
    random_payload(MAX_LEN);
    build_exp(4'h9);
    pulse_idx = 10;
    run_packet(4'h9, MAX_LEN + 5, cyc);
    reset_cfg();
    step();

    // Reset while byte 2 of 5 is on the bus.
    random_payload(5);
    build_exp(4'h1);
    abort_idx = 3;
    run_packet(4'h1, 5, cyc);
    reset_cfg();
    reset = 1'b1;
    step();
    reset = 1'b0; model_hist = '0; exp_fire = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hist", hist, 0);
    check("mid_rst_dready", data_ready, 0);
    $display("mid-packet reset checked");
    step();
    random_payload(5);
    build_exp(4'h1);
    run_packet(4'h1, 5, cyc);
    step();

    // Randomized packets with random source and sink throttling.
    for (int k = 0; k < 6; k++) begin
      logic [3:0] p;
      p   = 4'($urandom);
      len = $urandom_range(0, MAX_LEN + 3);
      random_payload((len > MAX_LEN) ? MAX_LEN : len);
      build_exp(p);
      ready_mode = 1; valid_rand = 1;
      run_packet(p, len, cyc);
      reset_cfg();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
